// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared types and constants for the CPU inst/data SRAM-port arbiter.
// Optional build macro: ARB_RAW_HOLD_EN adds write/address fields to each
// tag entry so that reads can be held behind outstanding writes to the same word.
package cpu_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_HOLD = 1'b1;

  typedef struct packed {
    logic        src;
`ifdef ARB_RAW_HOLD_EN
    logic        wr;
    logic [29:0] addr;
`endif
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/cpu_sram_arbiter_tag_fifo.sv
// In-order tag queue: remembers which requester owns each accepted request.
// Optional build macro: ARB_RAW_HOLD_EN exposes every entry and its valid bit
// so the arbiter can compare pending reads against queued writes.
module arb_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
`ifdef ARB_RAW_HOLD_EN
  ,
  output logic [DEPTH*WIDTH-1:0] snoop_data,
  output logic [DEPTH-1:0]       snoop_valid
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // pointer advance with explicit wrap so a depth of 1 stays at slot 0
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // status flags and guarded push/pop strobes
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // storage array, written only on a push
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers and occupancy count
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_RAW_HOLD_EN
  logic [DEPTH-1:0] vld;

  // per-slot valid bits so every live entry can be snooped
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld <= '0;
    end else begin
      if (do_pop)  vld[rd_ptr] <= 1'b0;
      if (do_push) vld[wr_ptr] <= 1'b1;
    end
  end

  // flatten the storage for the address compare in the arbiter
  always_comb begin
    snoop_data = '0;
    for (int unsigned j = 0; j < DEPTH; j++) snoop_data[j*WIDTH +: WIDTH] = mem[j];
    snoop_valid = vld;
  end
`endif

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Merges the CPU inst and data SRAM-like ports into one port for the AXI bridge.
// Data wins by default; inst is forced after STARVE_MAX data grants in a row.
// A granted request is held until accepted; responses are routed in order
// through a tag queue of depth OUTSTANDING.
// Optional build macro: ARB_RAW_HOLD_EN holds back reads that hit a queued write.
module cpu_sram_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 2);

  logic [0:0]    state;
  logic          gnt_src;
  logic [SW-1:0] starve_cnt;
  logic          i_elig;
  logic          d_elig;
  logic          cur_valid;
  logic          cur_src;
  logic          accept;
  logic          pop;
  logic          full;
  logic          empty;
  tag_t          push_tag;
  tag_t          head_tag;

`ifdef ARB_RAW_HOLD_EN
  logic [OUTSTANDING*TAG_W-1:0] snoop_data;
  logic [OUTSTANDING-1:0]       snoop_valid;
  logic                         i_hit;
  logic                         d_hit;
  logic                         unused_bits;

  // word-address match of each candidate against every queued write
  always_comb begin
    i_hit = 1'b0;
    d_hit = 1'b0;
    for (int unsigned j = 0; j < OUTSTANDING; j++) begin
      if (snoop_valid[j] && snoop_data[j*TAG_W + 30]) begin
        if (snoop_data[j*TAG_W +: 30] == i_addr[31:2]) i_hit = 1'b1;
        if (snoop_data[j*TAG_W +: 30] == d_addr[31:2]) d_hit = 1'b1;
      end
    end
    i_elig = i_req && !(!i_wr && i_hit);
    d_elig = d_req && !(!d_wr && d_hit);
  end

  assign unused_bits = ^{head_tag, snoop_data};
`else
  // without the hazard check every raised request is eligible
  always_comb begin
    i_elig = i_req;
    d_elig = d_req;
  end
`endif

  // grant selection: fresh choice in IDLE, latched source in HOLD
  always_comb begin
    cur_valid = 1'b0;
    cur_src   = SRC_DATA;
    if (state == ARB_HOLD) begin
      cur_valid = 1'b1;
      cur_src   = gnt_src;
    end else begin
      cur_valid = i_elig || d_elig;
      if (i_elig && ((starve_cnt == SW'(STARVE_MAX)) || !d_elig)) cur_src = SRC_INST;
    end
  end

  // merged request, payload mux, handshakes and response routing
  always_comb begin
    m_req     = cur_valid && !full && !areset;
    m_wr      = (cur_src == SRC_INST) ? i_wr    : d_wr;
    m_size    = (cur_src == SRC_INST) ? i_size  : d_size;
    m_addr    = (cur_src == SRC_INST) ? i_addr  : d_addr;
    m_wstrb   = (cur_src == SRC_INST) ? i_wstrb : d_wstrb;
    m_wdata   = (cur_src == SRC_INST) ? i_wdata : d_wdata;
    accept    = m_req && m_addr_ok;
    i_addr_ok = accept && (cur_src == SRC_INST);
    d_addr_ok = accept && (cur_src == SRC_DATA);
    pop       = m_data_ok && !empty && !areset;
    i_data_ok = pop && (head_tag.src == SRC_INST);
    d_data_ok = pop && (head_tag.src == SRC_DATA);
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
    push_tag  = '0;
    push_tag.src = cur_src;
`ifdef ARB_RAW_HOLD_EN
    push_tag.wr   = m_wr;
    push_tag.addr = m_addr[31:2];
`endif
  end

  // IDLE/HOLD state and latched grant source
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= ARB_IDLE;
      gnt_src <= SRC_INST;
    end else if (state == ARB_IDLE) begin
      if (m_req && !m_addr_ok) begin
        state   <= ARB_HOLD;
        gnt_src <= cur_src;
      end
    end else if (accept) begin
      state <= ARB_IDLE;
    end
  end

  // consecutive data acceptances seen while inst is waiting
  always_ff @(posedge aclk) begin
    if (areset) begin
      starve_cnt <= '0;
    end else if ((accept && (cur_src == SRC_INST)) || !i_req) begin
      starve_cnt <= '0;
    end else if (accept && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  arb_tag_fifo #(
    .WIDTH(TAG_W),
    .DEPTH(OUTSTANDING)
  ) u_tag_fifo (
    .aclk       (aclk),
    .areset     (areset),
    .push       (accept),
    .push_data  (push_tag),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head_tag)
`ifdef ARB_RAW_HOLD_EN
    ,
    .snoop_data (snoop_data),
    .snoop_valid(snoop_valid)
`endif
  );

`ifndef SYNTHESIS
  // the bridge must never answer when nothing is in flight
  a_no_orphan_resp: assert property (@(posedge aclk) disable iff (areset) !(m_data_ok && empty));
`endif

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter (OUTSTANDING=2, STARVE_MAX=3).
// Build with ARB_RAW_HOLD_EN defined to include the read-after-write hold scenario.
module tb_cpu_sram_arbiter;

  localparam logic SI = 1'b0;
  localparam logic SD = 1'b1;

  logic        aclk = 1'b0;
  logic        areset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size, m_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, i_rdata, d_rdata;
  logic [3:0]  i_wstrb, d_wstrb, m_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic        acc_q[$];
  logic        resp_q[$];
  logic [31:0] rdata_q[$];
  logic        e;
  logic [31:0] er;

  always #5 aclk = ~aclk;

  cpu_sram_arbiter #(.OUTSTANDING(2), .STARVE_MAX(3)) dut (
    .aclk(aclk), .areset(areset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wstrb(i_wstrb), .i_wdata(i_wdata), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic drive_idle();
    i_req = 1'b0; i_wr = 1'b0; i_size = 2'd2; i_addr = '0; i_wstrb = 4'hf; i_wdata = '0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'd2; d_addr = '0; d_wstrb = 4'hf; d_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
  endtask

  // one cycle of m_data_ok per queued response, routing checked against resp_q
  task automatic drain(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk); #1;
      drive_idle();
      m_data_ok = 1'b1; m_rdata = 32'hD000_0000 + 32'(k);
      @(negedge aclk);
      e = resp_q.pop_front();
      n_checks++;
      if ({i_data_ok, d_data_ok} !== ((e == SI) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL %s_drain%0d: i/d_data_ok=%b required %b", tag, k,
                 {i_data_ok, d_data_ok}, (e == SI) ? 2'b10 : 2'b01);
      end
    end
    @(posedge aclk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if ({m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000",
               {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic test_starve();
    acc_q = '{SD, SD, SD, SI, SD, SD, SD, SI};
    resp_q.delete();
    for (int k = 0; k < 9; k++) begin
      @(posedge aclk); #1;
      i_req = (k < 8); d_req = (k < 8);
      i_addr = 32'h0000_0100 + 32'(k * 4);
      d_addr = 32'h0000_0800 + 32'(k * 4);
      m_addr_ok = 1'b1;
      m_data_ok = (k >= 1);
      m_rdata = 32'hA000_0000 + 32'(k);
      @(negedge aclk);
      if (m_data_ok) begin
        e = resp_q.pop_front();
        n_checks++;
        if ({i_data_ok, d_data_ok, (e == SI) ? i_rdata : d_rdata} !==
            {(e == SI), (e == SD), 32'hA000_0000 + 32'(k)}) begin
          n_fail++;
          $display("FAIL starve_resp%0d: i/d_data_ok=%b rdata=%h required src=%b rdata=%h",
                   k, {i_data_ok, d_data_ok}, m_rdata, e, 32'hA000_0000 + 32'(k));
        end
      end
      if (k < 8) begin
        e = acc_q.pop_front();
        n_checks++;
        if ({i_addr_ok, d_addr_ok} !== ((e == SI) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL starve_order%0d: i/d_addr_ok=%b required %b", k,
                   {i_addr_ok, d_addr_ok}, (e == SI) ? 2'b10 : 2'b01);
        end
        resp_q.push_back(e);
      end
    end
    @(posedge aclk); #1;
    drive_idle();
  endtask

  task automatic test_hold();
    resp_q.delete();
    @(posedge aclk); #1;
    i_req = 1'b1; i_addr = 32'h0000_2000;
    @(negedge aclk);
    n_checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h0000_2000}) begin
      n_fail++;
      $display("FAIL hold_grant: m_req=%b m_addr=%h required 1 00002000", m_req, m_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk); #1;
      d_req = 1'b1; d_addr = 32'h0000_3000;
      @(negedge aclk);
      n_checks++;
      if ({m_req, m_addr, i_addr_ok, d_addr_ok} !== {1'b1, 32'h0000_2000, 2'b00}) begin
        n_fail++;
        $display("FAIL hold_stable%0d: m_req=%b m_addr=%h ok=%b required 1 00002000 00",
                 k, m_req, m_addr, {i_addr_ok, d_addr_ok});
      end
    end
    @(posedge aclk); #1;
    m_addr_ok = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({m_addr, i_addr_ok, d_addr_ok} !== {32'h0000_2000, 2'b10}) begin
      n_fail++;
      $display("FAIL hold_accept: m_addr=%h ok=%b required 00002000 10", m_addr, {i_addr_ok, d_addr_ok});
    end
    resp_q.push_back(SI);
    @(posedge aclk); #1;
    i_req = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({m_addr, i_addr_ok, d_addr_ok} !== {32'h0000_3000, 2'b01}) begin
      n_fail++;
      $display("FAIL hold_next: m_addr=%h ok=%b required 00003000 01", m_addr, {i_addr_ok, d_addr_ok});
    end
    resp_q.push_back(SD);
    drain("hold", 2);
  endtask

  task automatic test_throttle();
    resp_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      d_req = 1'b1; d_addr = 32'h0000_0010 + 32'(k * 4); m_addr_ok = 1'b1;
      @(negedge aclk);
      n_checks++;
      if (d_addr_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL throttle_fill%0d: d_addr_ok=%b required 1", k, d_addr_ok);
      end
      resp_q.push_back(SD);
    end
    @(posedge aclk); #1;
    d_addr = 32'h0000_0018;
    @(negedge aclk);
    n_checks++;
    if ({m_req, d_addr_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL throttle_full: m_req/d_addr_ok=%b required 00", {m_req, d_addr_ok});
    end
    @(posedge aclk); #1;
    m_data_ok = 1'b1; m_rdata = 32'h0000_5555;
    @(negedge aclk);
    e = resp_q.pop_front();
    n_checks++;
    if ({m_req, d_data_ok, d_rdata} !== {1'b0, (e == SD), 32'h0000_5555}) begin
      n_fail++;
      $display("FAIL throttle_pop: m_req=%b d_data_ok=%b d_rdata=%h required 0 1 00005555",
               m_req, d_data_ok, d_rdata);
    end
    @(posedge aclk); #1;
    m_data_ok = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({m_req, d_addr_ok} !== 2'b11) begin
      n_fail++;
      $display("FAIL throttle_resume: m_req/d_addr_ok=%b required 11", {m_req, d_addr_ok});
    end
    resp_q.push_back(SD);
    drain("throttle", 2);
  endtask

  task automatic test_resp_order();
    resp_q.delete();
    rdata_q.delete();
    @(posedge aclk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0040; m_addr_ok = 1'b1;
    @(negedge aclk);
    resp_q.push_back(SI); rdata_q.push_back(32'h1111_1111);
    @(posedge aclk); #1;
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0080;
    @(negedge aclk);
    resp_q.push_back(SD); rdata_q.push_back(32'h2222_2222);
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      drive_idle();
      m_data_ok = 1'b1; m_rdata = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
      @(negedge aclk);
      e = resp_q.pop_front();
      er = rdata_q.pop_front();
      n_checks++;
      if ({i_data_ok, d_data_ok, (e == SI) ? i_rdata : d_rdata} !== {(e == SI), (e == SD), er}) begin
        n_fail++;
        $display("FAIL resp_order%0d: i/d_data_ok=%b rdata=%h required src=%b rdata=%h",
                 k, {i_data_ok, d_data_ok}, m_rdata, e, er);
      end
    end
    @(posedge aclk); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid_hold();
    resp_q.delete();
    @(posedge aclk); #1;
    d_req = 1'b1; d_addr = 32'h0000_0050; m_addr_ok = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0060; m_addr_ok = 1'b0;
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      drive_idle();
      areset = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hBAD0_0000;
      @(negedge aclk);
      n_checks++;
      if ({i_data_ok, d_data_ok} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_drop%0d: i/d_data_ok=%b required 00", k, {i_data_ok, d_data_ok});
      end
    end
    @(posedge aclk); #1;
    drive_idle();
    areset = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_cleared: m_req=%b required 0", m_req);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      d_req = 1'b1; d_addr = 32'h0000_0070 + 32'(k * 4); m_addr_ok = 1'b1;
      @(negedge aclk);
      n_checks++;
      if ({i_addr_ok, d_addr_ok} !== 2'b01) begin
        n_fail++;
        $display("FAIL reset_refill%0d: i/d_addr_ok=%b required 01", k, {i_addr_ok, d_addr_ok});
      end
      resp_q.push_back(SD);
    end
    @(posedge aclk); #1;
    d_addr = 32'h0000_0078;
    @(negedge aclk);
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_queue_empty: m_req=%b required 0", m_req);
    end
    drain("reset", 2);
  endtask

`ifdef ARB_RAW_HOLD_EN
  task automatic test_raw();
    resp_q.delete();
    @(posedge aclk); #1;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_1000; m_addr_ok = 1'b1;
    @(negedge aclk);
    resp_q.push_back(SD);
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      d_req = 1'b0; d_wr = 1'b0; i_req = 1'b1; i_addr = 32'h0000_1002;
      @(negedge aclk);
      n_checks++;
      if ({m_req, i_addr_ok} !== 2'b00) begin
        n_fail++;
        $display("FAIL raw_block%0d: m_req/i_addr_ok=%b required 00", k, {m_req, i_addr_ok});
      end
    end
    @(posedge aclk); #1;
    m_data_ok = 1'b1;
    @(negedge aclk);
    e = resp_q.pop_front();
    n_checks++;
    if ({d_data_ok, i_addr_ok} !== {(e == SD), 1'b0}) begin
      n_fail++;
      $display("FAIL raw_release: d_data_ok/i_addr_ok=%b required 10", {d_data_ok, i_addr_ok});
    end
    @(posedge aclk); #1;
    m_data_ok = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (i_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_after: i_addr_ok=%b required 1", i_addr_ok);
    end
    resp_q.push_back(SI);
    @(posedge aclk); #1;
    i_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_1000; m_data_ok = 1'b1;
    @(negedge aclk);
    e = resp_q.pop_front();
    n_checks++;
    if ({i_data_ok, d_addr_ok} !== {(e == SI), 1'b1}) begin
      n_fail++;
      $display("FAIL raw_write2: i_data_ok/d_addr_ok=%b required 11", {i_data_ok, d_addr_ok});
    end
    resp_q.push_back(SD);
    @(posedge aclk); #1;
    d_req = 1'b0; d_wr = 1'b0; m_data_ok = 1'b0; i_req = 1'b1; i_addr = 32'h0000_1004;
    @(negedge aclk);
    n_checks++;
    if (i_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_other_word: i_addr_ok=%b required 1", i_addr_ok);
    end
    resp_q.push_back(SI);
    drain("raw", 2);
  endtask
`endif

  initial begin
    drive_idle();
    areset = 1'b1;
    test_reset();
    test_starve();
    test_hold();
    test_throttle();
    test_resp_order();
    test_reset_mid_hold();
`ifdef ARB_RAW_HOLD_EN
    test_raw();
`endif
    repeat (2) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
